// File: rtl/ascon_permutation_ctrl.sv
// ascon_permutation_ctrl
// Sequences the iterated ASCON permutation. The round function (constant
// addition, substitution, linear diffusion) sits outside this block. This
// block holds the 320-bit state and the round counter, supplies the round
// constant, and captures the datapath output once per clock. A start/done
// handshake connects it to the mode FSM above.

module ascon_permutation_ctrl #(
  parameter int NB_ROUNDS_MAX = 12
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       nb_rounds_i,
  input  logic [4:0][63:0] state_i,
  input  logic [4:0][63:0] round_state_i,
  output logic [4:0][63:0] state_o,
  output logic [3:0]       round_o,
  output logic [7:0]       const_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [3:0] ROUNDS_MAX = 4'(NB_ROUNDS_MAX);
  localparam logic [3:0] LAST_ROUND = 4'(NB_ROUNDS_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  fsm_t fsm_q;
  logic legal_rounds;

  // Only p^a (12 rounds) and the two p^b variants (6 or 8 rounds) are accepted.
  always_comb begin
    legal_rounds = (nb_rounds_i == 4'd6) || (nb_rounds_i == 4'd8) ||
                   (nb_rounds_i == 4'd12);
  end

  // The round constant is derived directly from the round index.
  assign const_o = {4'hF - round_o, round_o};

  // Control FSM. The state register, round counter and status flags are all registered here.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_o <= '0;
      round_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (fsm_q)
        IDLE, DONE: begin
          fsm_q <= IDLE;
          if (start_i) begin
            if (legal_rounds) begin
              state_o <= state_i;
              round_o <= ROUNDS_MAX - nb_rounds_i;
              busy_o  <= 1'b1;
              fsm_q   <= RUN;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        RUN: begin
          state_o <= round_state_i;
          if (round_o == LAST_ROUND) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            fsm_q  <= DONE;
          end else begin
            round_o <= round_o + 4'd1;
          end
        end
        default: begin
          fsm_q  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// tb_ascon_permutation_ctrl
// Scoreboard bench for ascon_permutation_ctrl. The stub round only XORs the
// round constant into the low byte of S[2]. Because of that, the final state
// can be derived by hand from the sequence of round constants.

module tb_ascon_permutation_ctrl;

  typedef struct {
    bit               is_err;
    logic [4:0][63:0] st;
    int               rounds;
    int               gap;
  } exp_t;

  logic             clock_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             start_i = 1'b0;
  logic [3:0]       nb_rounds_i = 4'd0;
  logic [4:0][63:0] state_i = '0;
  logic [4:0][63:0] round_state_i;
  logic [4:0][63:0] state_o;
  logic [3:0]       round_o;
  logic [7:0]       const_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  int checks = 0;
  int errors = 0;

  exp_t       sb_q[$];
  logic [7:0] const_q[$];

  logic [7:0] const_table [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                   8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

  logic [4:0][63:0] s_init;
  logic [4:0][63:0] s_other;
  logic [4:0][63:0] s_six;

  ascon_permutation_ctrl #(.NB_ROUNDS_MAX(12)) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .nb_rounds_i   (nb_rounds_i),
    .state_i       (state_i),
    .round_state_i (round_state_i),
    .state_o       (state_o),
    .round_o       (round_o),
    .const_o       (const_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  // Stub round: XOR the constant into the low byte of S[2].
  always_comb begin
    round_state_i    = state_o;
    round_state_i[2] = state_o[2] ^ {56'h0, const_o};
  end

  // Free-running clock with a 10 ns period.
  always #5 clock_i = ~clock_i;

  task automatic checkOutput(input string name, input logic [319:0] act,
                             input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic pushRun(input int n, input logic [4:0][63:0] st, input int gap);
    exp_t e;
    for (int i = 12 - n; i < 12; i++) const_q.push_back(const_table[i]);
    e.is_err = 1'b0;
    e.st     = st;
    e.rounds = n;
    e.gap    = gap;
    sb_q.push_back(e);
  endtask

  task automatic pushErr(input logic [4:0][63:0] st);
    exp_t e;
    e.is_err = 1'b1;
    e.st     = st;
    e.rounds = 0;
    e.gap    = 0;
    sb_q.push_back(e);
  endtask

  // Drive a single-cycle start. The rising edge inside this task is the accept edge.
  task automatic applyStimulus(input logic [3:0] nb, input logic [4:0][63:0] st);
    start_i     = 1'b1;
    nb_rounds_i = nb;
    state_i     = st;
    tick();
    start_i = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles, input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || const_q.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0 || const_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: %0d responses and %0d rounds still pending, expected 0",
               name, sb_q.size(), const_q.size());
      sb_q.delete();
      const_q.delete();
    end
    tick();
    tick();
  endtask

  // Monitor: compares every busy cycle, done pulse and err pulse against the queues.
  initial begin
    int   cycle;
    int   busy_cnt;
    int   last_done;
    exp_t e;
    logic [7:0] c;
    cycle     = 0;
    busy_cnt  = 0;
    last_done = 0;
    forever begin
      @(negedge clock_i);
      cycle++;
      if (reset_i) begin
        busy_cnt = 0;
      end else begin
        if (busy_o) begin
          busy_cnt++;
          if (const_q.size() == 0) begin
            checkOutput("unexpected_busy", 320'(busy_o), 320'(1'b0));
          end else begin
            c = const_q.pop_front();
            checkOutput("const_o", 320'(const_o), 320'(c));
            checkOutput("round_o", 320'(round_o), 320'(c[3:0]));
          end
        end
        if (done_o) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_done", 320'(done_o), 320'(1'b0));
          end else begin
            e = sb_q.pop_front();
            checkOutput("done_kind", 320'(e.is_err), 320'(1'b0));
            checkOutput("final_state", state_o, e.st);
            checkOutput("busy_cycles", 320'(busy_cnt), 320'(e.rounds));
            checkOutput("busy_at_done", 320'(busy_o), 320'(1'b0));
            checkOutput("err_at_done", 320'(err_o), 320'(1'b0));
            if (e.gap > 0) checkOutput("done_gap", 320'(cycle - last_done), 320'(e.gap));
          end
          last_done = cycle;
          busy_cnt  = 0;
        end
        if (err_o) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_err", 320'(err_o), 320'(1'b0));
          end else begin
            e = sb_q.pop_front();
            checkOutput("err_kind", 320'(e.is_err), 320'(1'b1));
            checkOutput("err_state", state_o, e.st);
            checkOutput("err_busy", 320'(busy_o), 320'(1'b0));
          end
        end
      end
    end
  end

  // Directed scenarios.
  initial begin
    s_init[0] = 64'h80400c0600000000;
    s_init[1] = 64'h0001020304050607;
    s_init[2] = 64'h08090a0b0c0d0eff;
    s_init[3] = 64'h0011223344556677;
    s_init[4] = 64'h8899aabbccddeeff;
    s_other    = s_init;
    s_other[0] = 64'hdeadbeefcafef00d;
    s_other[3] = 64'h0123456789abcdef;
    s_six      = s_init;
    s_six[2]   = 64'h08090a0b0c0d0eee;

    $display("[TB] reset");
    tick();
    checkOutput("rst_state", state_o, '0);
    checkOutput("rst_round", 320'(round_o), 320'(4'd0));
    checkOutput("rst_const", 320'(const_o), 320'(8'hF0));
    checkOutput("rst_busy", 320'(busy_o), 320'(1'b0));
    checkOutput("rst_done", 320'(done_o), 320'(1'b0));
    checkOutput("rst_err", 320'(err_o), 320'(1'b0));
    tick();
    reset_i = 1'b0;
    tick();

    $display("[TB] scenario 1: p^a");
    pushRun(12, s_init, 0);
    applyStimulus(4'd12, s_init);
    waitDrain(40, "s1");

    $display("[TB] scenario 2: p^b 6 rounds");
    pushRun(6, s_six, 0);
    applyStimulus(4'd6, s_init);
    waitDrain(40, "s2");

    $display("[TB] scenario 3: p^b 8 rounds then illegal count");
    pushRun(8, s_init, 0);
    applyStimulus(4'd8, s_init);
    waitDrain(40, "s3a");
    pushErr(s_init);
    applyStimulus(4'd7, s_other);
    waitDrain(10, "s3b");
    checkOutput("err_state_kept", state_o, s_init);

    $display("[TB] scenario 4: start ignored while running");
    pushRun(12, s_init, 0);
    applyStimulus(4'd12, s_init);
    repeat (5) tick();
    start_i     = 1'b1;
    nb_rounds_i = 4'd6;
    state_i     = s_other;
    tick();
    start_i = 1'b0;
    waitDrain(40, "s4");

    $display("[TB] scenario 5: reset mid-run");
    for (int i = 0; i < 6; i++) const_q.push_back(const_table[i]);
    applyStimulus(4'd12, s_init);
    repeat (5) tick();
    checkOutput("pre_reset_round", 320'(round_o), 320'(4'd5));
    @(negedge clock_i);
    #1;
    reset_i = 1'b1;
    #1;
    checkOutput("abort_state", state_o, '0);
    checkOutput("abort_busy", 320'(busy_o), 320'(1'b0));
    checkOutput("abort_round", 320'(round_o), 320'(4'd0));
    checkOutput("abort_const", 320'(const_o), 320'(8'hF0));
    tick();
    tick();
    reset_i = 1'b0;
    repeat (15) tick();
    checkOutput("abort_pending_rounds", 320'(const_q.size()), 320'(0));
    pushRun(8, s_init, 0);
    applyStimulus(4'd8, s_init);
    waitDrain(40, "s5");

    $display("[TB] scenario 6: back-to-back");
    pushRun(6, s_six, 0);
    pushRun(6, s_six, 7);
    start_i     = 1'b1;
    nb_rounds_i = 4'd6;
    state_i     = s_init;
    repeat (8) tick();
    start_i = 1'b0;
    waitDrain(40, "s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
